lbp_port_arbiter: RTL and testbench

Shares the single gray-image read port and the single LBP result write port of the 128x128 LBP test harness between two LBP window engines (requester 0 and requester 1), so the image can be split into two halves and processed concurrently. Reads are granted round-robin with a burst lock sized to one 3x3 window (9 reads), so each engine completes a window without interleaving. Writes are merged onto the result port, and a combined `finish` is raised once both engines report done.

---
 rtl/lbp_port_arbiter.sv | 178 +++++++++++++++++
 tb/tb_lbp_port_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lbp_port_arbiter.sv
// Shares one gray-image read port and one LBP result write port between two window engines.
// Reads are round-robin with a per-owner burst lock; writes are merged; finish is the AND of both.
module lbp_port_arbiter #(
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_req,
  input  logic              r1_req,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [ADDR_W-1:0] r1_addr,
  output logic              r0_gnt,
  output logic              r1_gnt,
  output logic              r0_rvalid,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [ADDR_W-1:0] gray_addr,
  output logic              gray_req,
  input  logic              gray_ready,
  input  logic [DATA_W-1:0] gray_data,
  input  logic              w0_valid,
  input  logic              w1_valid,
  input  logic [ADDR_W-1:0] w0_addr,
  input  logic [ADDR_W-1:0] w1_addr,
  input  logic [DATA_W-1:0] w0_data,
  input  logic [DATA_W-1:0] w1_data,
  output logic              w0_ack,
  output logic              w1_ack,
  output logic [ADDR_W-1:0] lbp_addr,
  output logic [DATA_W-1:0] lbp_data,
  output logic              lbp_valid,
  input  logic              finish0_in,
  input  logic              finish1_in,
  output logic              finish
);

  localparam logic [3:0] MaxBurst = 4'(MAX_BURST);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1, StDone} state_e;

  state_e              state_q, state_d;
  logic [3:0]          bcnt_q, bcnt_d;
  logic                last_q, last_d;
  logic [1:0]          tag_q, tag_d;
  logic                wlast_q, wlast_d;
  logic                f0_q, f0_d, f1_q, f1_d;
  logic                finish_q, finish_d;
  logic [ADDR_W-1:0]   lbp_addr_q, lbp_addr_d;
  logic [DATA_W-1:0]   lbp_data_q, lbp_data_d;
  logic                lbp_valid_q, lbp_valid_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      bcnt_q      <= 4'd0;
      last_q      <= 1'b1;
      tag_q       <= 2'b00;
      wlast_q     <= 1'b1;
      f0_q        <= 1'b0;
      f1_q        <= 1'b0;
      finish_q    <= 1'b0;
      lbp_addr_q  <= '0;
      lbp_data_q  <= '0;
      lbp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bcnt_q      <= bcnt_d;
      last_q      <= last_d;
      tag_q       <= tag_d;
      wlast_q     <= wlast_d;
      f0_q        <= f0_d;
      f1_q        <= f1_d;
      finish_q    <= finish_d;
      lbp_addr_q  <= lbp_addr_d;
      lbp_data_q  <= lbp_data_d;
      lbp_valid_q <= lbp_valid_d;
    end
  end

  // Grant decode: the owner keeps the port until it releases or hits the burst lock with a waiter.
  always_comb begin
    r0_gnt = 1'b0;
    r1_gnt = 1'b0;
    if (!reset && gray_ready && !finish_q) begin
      unique case (state_q)
        StIdle: begin
          if (r0_req || r1_req) begin
            if (last_q) begin
              r0_gnt = r0_req;
              r1_gnt = !r0_req;
            end else begin
              r1_gnt = r1_req;
              r0_gnt = !r1_req;
            end
          end
        end
        StOwn0: begin
          if (r0_req && ((bcnt_q < MaxBurst) || !r1_req)) r0_gnt = 1'b1;
          else                                          r1_gnt = r1_req;
        end
        StOwn1: begin
          if (r1_req && ((bcnt_q < MaxBurst) || !r0_req)) r1_gnt = 1'b1;
          else                                          r0_gnt = r0_req;
        end
        default: ;
      endcase
    end
    gray_req  = r0_gnt | r1_gnt;
    gray_addr = r0_gnt ? r0_addr : (r1_gnt ? r1_addr : '0);
    r0_rvalid = tag_q[0];
    r1_rvalid = tag_q[1];
    r0_rdata  = reset ? '0 : gray_data;
    r1_rdata  = reset ? '0 : gray_data;
    tag_d     = {r1_gnt, r0_gnt};
  end

  // Next state follows the grant just issued; a grant-free cycle with the port ready means release.
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    last_d  = last_q;
    if (finish_q) begin
      state_d = StDone;
    end else if (r0_gnt) begin
      bcnt_d  = ((state_q == StOwn0) && (bcnt_q < MaxBurst)) ? bcnt_q + 4'd1 : 4'd1;
      if (state_q == StOwn1) last_d = 1'b1;
      state_d = StOwn0;
    end else if (r1_gnt) begin
      bcnt_d  = ((state_q == StOwn1) && (bcnt_q < MaxBurst)) ? bcnt_q + 4'd1 : 4'd1;
      if (state_q == StOwn0) last_d = 1'b0;
      state_d = StOwn1;
    end else if (gray_ready && (state_q == StOwn0)) begin
      state_d = StIdle;
      last_d  = 1'b0;
    end else if (gray_ready && (state_q == StOwn1)) begin
      state_d = StIdle;
      last_d  = 1'b1;
    end
  end

  always_comb begin
    w0_ack  = 1'b0;
    w1_ack  = 1'b0;
    wlast_d = wlast_q;
    if (!reset && !finish_q) begin
      if (w0_valid && w1_valid) begin
        w0_ack  = wlast_q;
        w1_ack  = !wlast_q;
        wlast_d = !wlast_q;
      end else begin
        w0_ack = w0_valid;
        w1_ack = w1_valid;
      end
    end
    lbp_valid_d = w0_ack | w1_ack;
    lbp_addr_d  = lbp_addr_q;
    lbp_data_d  = lbp_data_q;
    if (w0_ack) begin
      lbp_addr_d = w0_addr;
      lbp_data_d = w0_data;
    end else if (w1_ack) begin
      lbp_addr_d = w1_addr;
      lbp_data_d = w1_data;
    end
    f0_d     = f0_q | finish0_in;
    f1_d     = f1_q | finish1_in;
    finish_d = finish_q | (f0_d & f1_d);
  end

  assign lbp_addr  = lbp_addr_q;
  assign lbp_data  = lbp_data_q;
  assign lbp_valid = lbp_valid_q;
  assign finish    = finish_q;

endmodule

// File: tb/tb_lbp_port_arbiter.sv
// Directed plus randomized bench for lbp_port_arbiter against a cycle-level behavioural model.
module tb_lbp_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        r0_req, r1_req, r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
  logic [13:0] r0_addr, r1_addr, gray_addr, w0_addr, w1_addr, lbp_addr;
  logic [7:0]  r0_rdata, r1_rdata, gray_data, w0_data, w1_data, lbp_data;
  logic        gray_req, gray_ready, w0_valid, w1_valid, w0_ack, w1_ack, lbp_valid;
  logic        finish0_in, finish1_in, finish;

  lbp_port_arbiter dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r1_req(r1_req), .r0_addr(r0_addr), .r1_addr(r1_addr),
    .r0_gnt(r0_gnt), .r1_gnt(r1_gnt), .r0_rvalid(r0_rvalid), .r1_rvalid(r1_rvalid),
    .r0_rdata(r0_rdata), .r1_rdata(r1_rdata), .gray_addr(gray_addr), .gray_req(gray_req),
    .gray_ready(gray_ready), .gray_data(gray_data),
    .w0_valid(w0_valid), .w1_valid(w1_valid), .w0_addr(w0_addr), .w1_addr(w1_addr),
    .w0_data(w0_data), .w1_data(w1_data), .w0_ack(w0_ack), .w1_ack(w1_ack),
    .lbp_addr(lbp_addr), .lbp_data(lbp_data), .lbp_valid(lbp_valid),
    .finish0_in(finish0_in), .finish1_in(finish1_in), .finish(finish)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: owner -1 means nobody holds the port.
  int          m_owner, m_cnt, m_last, m_wlast;
  bit          m_done, m_fin, m_f0, m_f1, m_lvalid;
  logic [1:0]  m_tag;
  logic [13:0] m_raddr, m_laddr;
  logic [7:0]  m_ldata;
  int          exp_g, exp_a;
  logic [1:0]  dut_gnt;
  logic        mem_pend;
  logic [13:0] mem_addr;
  logic [13:0] a9 [9];

  function automatic logic [7:0] memf(input logic [13:0] a);
    return a[7:0] ^ {a[13:8], 2'b01} ^ 8'h5A;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_cnt = 0; m_last = 1; m_wlast = 1;
    m_done = 0; m_fin = 0; m_f0 = 0; m_f1 = 0; m_lvalid = 0;
    m_tag = 2'b00; m_raddr = '0; m_laddr = '0; m_ldata = '0;
    mem_pend = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset();
    #1;
    check("rst_r0_gnt", 32'(r0_gnt), 0);       check("rst_r1_gnt", 32'(r1_gnt), 0);
    check("rst_gray_req", 32'(gray_req), 0);   check("rst_gray_addr", 32'(gray_addr), 0);
    check("rst_w0_ack", 32'(w0_ack), 0);       check("rst_w1_ack", 32'(w1_ack), 0);
    check("rst_r0_rvalid", 32'(r0_rvalid), 0); check("rst_r1_rvalid", 32'(r1_rvalid), 0);
    check("rst_r0_rdata", 32'(r0_rdata), 0);   check("rst_r1_rdata", 32'(r1_rdata), 0);
    check("rst_lbp_addr", 32'(lbp_addr), 0);   check("rst_lbp_data", 32'(lbp_data), 0);
    check("rst_lbp_valid", 32'(lbp_valid), 0); check("rst_finish", 32'(finish), 0);
  endtask

  // One clock cycle: predict, compare, then advance the model across the rising edge.
  task automatic step();
    logic [1:0] rq;
    int pref, o;
    #1;
    rq = {r1_req, r0_req};
    exp_g = -1;
    if (!m_done && !m_fin && gray_ready) begin
      if (m_owner < 0) begin
        pref = 1 - m_last;
        if (rq[pref]) exp_g = pref;
        else if (rq[m_last]) exp_g = m_last;
      end else begin
        o = m_owner;
        if (rq[o] && (m_cnt < 9 || !rq[1-o])) exp_g = o;
        else if (rq[1-o]) exp_g = 1 - o;
      end
    end
    exp_a = -1;
    if (!m_fin) begin
      if (w0_valid && w1_valid) exp_a = (m_wlast == 1) ? 0 : 1;
      else if (w0_valid) exp_a = 0;
      else if (w1_valid) exp_a = 1;
    end
    dut_gnt = {r1_gnt, r0_gnt};
    check("r0_gnt", 32'(r0_gnt), 32'(exp_g == 0));
    check("r1_gnt", 32'(r1_gnt), 32'(exp_g == 1));
    check("gray_req", 32'(gray_req), 32'(exp_g >= 0));
    check("gray_addr", 32'(gray_addr),
          (exp_g == 0) ? 32'(r0_addr) : (exp_g == 1) ? 32'(r1_addr) : 32'd0);
    check("w0_ack", 32'(w0_ack), 32'(exp_a == 0));
    check("w1_ack", 32'(w1_ack), 32'(exp_a == 1));
    check("r0_rvalid", 32'(r0_rvalid), 32'(m_tag[0]));
    check("r1_rvalid", 32'(r1_rvalid), 32'(m_tag[1]));
    if (m_tag[0]) check("r0_rdata", 32'(r0_rdata), 32'(memf(m_raddr)));
    if (m_tag[1]) check("r1_rdata", 32'(r1_rdata), 32'(memf(m_raddr)));
    check("lbp_valid", 32'(lbp_valid), 32'(m_lvalid));
    check("lbp_addr", 32'(lbp_addr), 32'(m_laddr));
    check("lbp_data", 32'(lbp_data), 32'(m_ldata));
    check("finish", 32'(finish), 32'(m_fin));
    mem_pend = gray_req;
    mem_addr = gray_addr;
    @(posedge clk);
    m_tag = {exp_g == 1, exp_g == 0};
    if (exp_g >= 0) m_raddr = (exp_g == 0) ? r0_addr : r1_addr;
    if (m_fin) m_done = 1;
    else if (exp_g >= 0) begin
      if (exp_g == m_owner) m_cnt = (m_cnt < 9) ? m_cnt + 1 : 1;
      else begin
        if (m_owner >= 0) m_last = m_owner;
        m_cnt = 1;
      end
      m_owner = exp_g;
    end else if (gray_ready && m_owner >= 0) begin
      m_last  = m_owner;
      m_owner = -1;
    end
    m_lvalid = (exp_a >= 0);
    if (exp_a == 0) begin m_laddr = w0_addr; m_ldata = w0_data; end
    if (exp_a == 1) begin m_laddr = w1_addr; m_ldata = w1_data; end
    if (w0_valid && w1_valid && exp_a >= 0) m_wlast = exp_a;
    m_f0 = m_f0 | finish0_in;
    m_f1 = m_f1 | finish1_in;
    if (m_f0 && m_f1) m_fin = 1;
    #1;
    gray_data = mem_pend ? memf(mem_addr) : 8'($urandom);
    @(negedge clk);
  endtask

  // Requests stay up with a stable address until granted, then continue or drop at random.
  task automatic adv_req(input int pc_cont, input int pc_raise);
    if (r0_req && exp_g == 0) begin
      r0_req = ($urandom_range(99) < pc_cont); r0_addr = 14'($urandom);
    end else if (!r0_req && $urandom_range(99) < pc_raise) begin
      r0_req = 1'b1; r0_addr = 14'($urandom);
    end
    if (r1_req && exp_g == 1) begin
      r1_req = ($urandom_range(99) < pc_cont); r1_addr = 14'($urandom);
    end else if (!r1_req && $urandom_range(99) < pc_raise) begin
      r1_req = 1'b1; r1_addr = 14'($urandom);
    end
  endtask

  task automatic adv_wr(input int pc_cont, input int pc_raise);
    if (w0_valid && exp_a == 0) begin
      w0_valid = ($urandom_range(99) < pc_cont); w0_addr = 14'($urandom); w0_data = 8'($urandom);
    end else if (!w0_valid && $urandom_range(99) < pc_raise) begin
      w0_valid = 1'b1; w0_addr = 14'($urandom); w0_data = 8'($urandom);
    end
    if (w1_valid && exp_a == 1) begin
      w1_valid = ($urandom_range(99) < pc_cont); w1_addr = 14'($urandom); w1_data = 8'($urandom);
    end else if (!w1_valid && $urandom_range(99) < pc_raise) begin
      w1_valid = 1'b1; w1_addr = 14'($urandom); w1_data = 8'($urandom);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k, guard, ng;
    a9 = '{14'd0, 14'd1, 14'd2, 14'd128, 14'd129, 14'd130, 14'd256, 14'd257, 14'd258};
    reset = 1'b1;
    r0_req = 1'b1; r1_req = 1'b1; r0_addr = 14'd5; r1_addr = 14'd6;
    w0_valid = 1'b1; w1_valid = 1'b1; w0_addr = 14'd7; w1_addr = 14'd8;
    w0_data = 8'h11; w1_data = 8'h22; gray_ready = 1'b1; gray_data = 8'h77;
    finish0_in = 1'b0; finish1_in = 1'b0;
    model_reset();
    @(negedge clk);
    chk_reset();
    @(negedge clk);
    r0_req = 0; r1_req = 0; w0_valid = 0; w1_valid = 0;
    reset = 1'b0;

    // Single requester, one 3x3 window.
    k = 0; ng = 0;
    r0_req = 1'b1; r0_addr = a9[0];
    for (int c = 0; c < 12 && k < 9; c++) begin
      step();
      if (dut_gnt == 2'b01) ng++;
      if (exp_g == 0) k++;
      if (k < 9) r0_addr = a9[k];
      else r0_req = 1'b0;
    end
    check("single_burst_grants", 32'(ng), 32'd9);
    step(); step();

    // Contention: r1 wins the first tie since r0 was served last.
    r0_req = 1'b1; r1_req = 1'b1;
    for (int i = 0; i < 36; i++) begin
      step();
      check("contention_seq", 32'(dut_gnt), ((i / 9) % 2 == 0) ? 32'd2 : 32'd1);
      adv_req(100, 100);
    end
    r0_req = 1'b0; r1_req = 1'b0;
    step(); step();

    // Early release after 4 grants hands over in the same cycle.
    r0_req = 1'b1; r0_addr = 14'd300; k = 0; guard = 0;
    while (k < 4 && guard < 20) begin
      step();
      guard++;
      if (exp_g == 0) begin
        k++; r0_addr = 14'($urandom); r1_req = 1'b1; r1_addr = 14'd4000;
      end
    end
    r0_req = 1'b0;
    step();
    check("early_release", 32'(dut_gnt), 32'd2);
    r0_req = 1'b1; r0_addr = 14'd301; r1_addr = 14'($urandom);
    for (int i = 0; i < 12; i++) begin step(); adv_req(100, 100); end
    r0_req = 1'b0; r1_req = 1'b0;
    step(); step();

    // Reset mid-burst drops the in-flight read, then gray_ready gating.
    r0_req = 1'b1; r0_addr = 14'd77;
    step(); step();
    reset = 1'b1;
    chk_reset();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    gray_ready = 1'b0; r0_req = 1'b1; r1_req = 1'b1; r1_addr = 14'd99; ng = 0;
    for (int i = 0; i < 5; i++) begin step(); if (dut_gnt != 2'b00) ng++; end
    check("ready_low_grants", 32'(ng), 32'd0);
    gray_ready = 1'b1;
    step();
    check("ready_first_r0", 32'(dut_gnt), 32'd1);
    r0_req = 1'b0; r1_req = 1'b0;
    step(); step(); step();

    // Write merge with both writers contending.
    w0_valid = 1'b1; w0_addr = 14'd129;  w0_data = 8'hA5;
    w1_valid = 1'b1; w1_addr = 14'd8321; w1_data = 8'h3C;
    step();
    w0_valid = 1'b0;
    check("wm_first_valid", 32'(lbp_valid), 32'd1);
    check("wm_first_addr", 32'(lbp_addr), 32'd129);
    check("wm_first_data", 32'(lbp_data), 32'hA5);
    step();
    w1_valid = 1'b0;
    check("wm_second_valid", 32'(lbp_valid), 32'd1);
    check("wm_second_addr", 32'(lbp_addr), 32'd8321);
    check("wm_second_data", 32'(lbp_data), 32'h3C);
    step();
    check("wm_idle_valid", 32'(lbp_valid), 32'd0);

    // Randomized traffic on both ports.
    for (int i = 0; i < 800; i++) begin
      gray_ready = ($urandom_range(9) != 0);
      adv_req(80, 30);
      adv_wr(50, 40);
      step();
    end

    // Finish: second flag ten cycles after the first, then nothing is granted.
    gray_ready = 1'b1;
    finish0_in = 1'b1;
    step();
    finish0_in = 1'b0;
    for (int i = 0; i < 9; i++) begin adv_req(80, 50); adv_wr(50, 50); step(); end
    check("finish_not_yet", 32'(finish), 32'd0);
    finish1_in = 1'b1;
    adv_req(80, 50); adv_wr(50, 50);
    step();
    finish1_in = 1'b0;
    check("finish_set", 32'(finish), 32'd1);
    r0_req = 1'b1; r1_req = 1'b1; w0_valid = 1'b1; w1_valid = 1'b1; ng = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (dut_gnt != 2'b00 || w0_ack || w1_ack) ng++;
    end
    check("done_no_grants", 32'(ng), 32'd0);

    reset = 1'b1;
    chk_reset();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    r0_req = 1'b0; r1_req = 1'b0; w0_valid = 1'b0; w1_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin adv_req(70, 40); adv_wr(50, 40); step(); end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
